// File: rtl/ocx_bram_sdp_param.sv
// Parametrised simple-dual-port block RAM with byte enables, write-first forwarding, and a 1/2-stage read pipe.
// Optional per-byte even parity is enabled with the macro OCX_BRAM_PARITY_EN. The array is cleared after every reset.
module ocx_bram_sdp_param #(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 7,
  parameter int OUT_REG    = 1
) (
  input  logic                    clk,
  input  logic                    rstb,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  output logic                    rd_perr,
  output logic                    init_done
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {CLEAR, READY} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    if (state_q == CLEAR) begin
      clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
      if (clr_addr_q == ADDR_WIDTH'(DEPTH - 1)) state_d = READY;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk) begin
    if (rstb) begin
      state_q    <= CLEAR;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  assign init_done = (state_q == READY);

  // Single write port shared by the clear sequencer and user writes; nothing is written on a reset cycle.
  logic [NB-1:0]         mem_be;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  always_comb begin
    mem_be    = '0;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    if (!rstb) begin
      if (state_q == CLEAR) begin
        mem_be    = '1;
        mem_waddr = clr_addr_q;
        mem_wdata = '0;
      end else if (wr_en) begin
        mem_be = wr_be;
      end
    end
  end

  // NOTE: the storage array has no reset; the clear sequencer zeroes it instead.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (mem_be[b]) mem_q[mem_waddr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  // Array readout with write-first merge of colliding bytes.
  logic                  rd_accept;
  logic [DATA_WIDTH-1:0] rd_raw;
  logic [DATA_WIDTH-1:0] rd_merged;
  logic [NB-1:0]         rd_fwd;
  logic                  rd_perr_raw;

  assign rd_accept = rd_en && !rstb && (state_q == READY);
  assign rd_raw    = mem_q[rd_addr];

  always_comb begin
    rd_merged = rd_raw;
    rd_fwd    = '0;
    for (int b = 0; b < NB; b++) begin
      rd_fwd[b] = mem_be[b] && (mem_waddr == rd_addr);
      if (rd_fwd[b]) rd_merged[8*b +: 8] = mem_wdata[8*b +: 8];
    end
  end

`ifdef OCX_BRAM_PARITY_EN
  logic [NB-1:0] par_q [DEPTH];
  logic [NB-1:0] rd_par_raw;
  logic [NB-1:0] byte_perr;

  always_ff @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (mem_be[b]) par_q[mem_waddr][b] <= ^mem_wdata[8*b +: 8];
    end
  end

  assign rd_par_raw = par_q[rd_addr];

  // Forwarded bytes carry fresh parity and therefore can never mismatch.
  always_comb begin
    byte_perr = '0;
    for (int b = 0; b < NB; b++) begin
      byte_perr[b] = !rd_fwd[b] && ((^rd_raw[8*b +: 8]) != rd_par_raw[b]);
    end
  end

  assign rd_perr_raw = |byte_perr;
`else
  assign rd_perr_raw = 1'b0;
`endif

  // First read stage: data holds between reads, the error flag only travels with a valid read.
  logic                  rd_v1_q, rd_v1_d;
  logic [DATA_WIDTH-1:0] rd_data1_q, rd_data1_d;
  logic                  rd_perr1_q, rd_perr1_d;

  always_comb begin
    rd_v1_d    = rd_accept;
    rd_data1_d = rd_accept ? rd_merged : rd_data1_q;
    rd_perr1_d = rd_accept && rd_perr_raw;
  end

  always_ff @(posedge clk) begin
    if (rstb) begin
      rd_v1_q    <= 1'b0;
      rd_data1_q <= '0;
      rd_perr1_q <= 1'b0;
    end else begin
      rd_v1_q    <= rd_v1_d;
      rd_data1_q <= rd_data1_d;
      rd_perr1_q <= rd_perr1_d;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic                  rd_v2_q, rd_v2_d;
      logic [DATA_WIDTH-1:0] rd_data2_q, rd_data2_d;
      logic                  rd_perr2_q, rd_perr2_d;

      always_comb begin
        rd_v2_d    = rd_v1_q;
        rd_data2_d = rd_v1_q ? rd_data1_q : rd_data2_q;
        rd_perr2_d = rd_v1_q && rd_perr1_q;
      end

      always_ff @(posedge clk) begin
        if (rstb) begin
          rd_v2_q    <= 1'b0;
          rd_data2_q <= '0;
          rd_perr2_q <= 1'b0;
        end else begin
          rd_v2_q    <= rd_v2_d;
          rd_data2_q <= rd_data2_d;
          rd_perr2_q <= rd_perr2_d;
        end
      end

      assign rd_valid = rd_v2_q;
      assign rd_data  = rd_data2_q;
      assign rd_perr  = rd_perr2_q;
    end else begin : g_no_out_reg
      assign rd_valid = rd_v1_q;
      assign rd_data  = rd_data1_q;
      assign rd_perr  = rd_perr1_q;
    end
  endgenerate

endmodule

// File: tb/tb_ocx_bram_sdp_param.sv
// Directed bench for ocx_bram_sdp_param: a 2-cycle (OUT_REG=1) and a 1-cycle (OUT_REG=0) instance share one stimulus.
module tb_ocx_bram_sdp_param;

  localparam int DW = 512;
  localparam int AW = 7;
  localparam int NB = DW / 8;

  logic          clk = 1'b0;
  logic          rstb;
  logic          wr_en;
  logic [NB-1:0] wr_be;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic [AW-1:0] rd_addr;

  logic [DW-1:0] rd_data2, rd_data1;
  logic          rd_valid2, rd_valid1;
  logic          rd_perr2, rd_perr1;
  logic          init_done2, init_done1;

  int n_vec = 0;
  int n_bad = 0;
  logic seen_valid;

  always #5 clk = ~clk;

  ocx_bram_sdp_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUT_REG(1)) u_dut2 (
    .clk(clk), .rstb(rstb), .wr_en(wr_en), .wr_be(wr_be), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data2),
    .rd_valid(rd_valid2), .rd_perr(rd_perr2), .init_done(init_done2)
  );

  ocx_bram_sdp_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUT_REG(0)) u_dut1 (
    .clk(clk), .rstb(rstb), .wr_en(wr_en), .wr_be(wr_be), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1),
    .rd_valid(rd_valid1), .rd_perr(rd_perr1), .init_done(init_done1)
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [NB-1:0] be, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_be = be; wr_data = d;
    tick();
    wr_en = 1'b0; wr_be = '0;
  endtask

  // Single read: 1-cycle instance answers after one edge, 2-cycle instance after two.
  task automatic rd(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp, input logic exp_perr);
    rd_en = 1'b1; rd_addr = a;
    tick();
    rd_en = 1'b0;
    check({tag, "_v1"}, rd_valid1, 1'b1);
    check({tag, "_d1"}, rd_data1, exp);
    check({tag, "_p1"}, rd_perr1, exp_perr);
    check({tag, "_v2_early"}, rd_valid2, 1'b0);
    tick();
    check({tag, "_v2"}, rd_valid2, 1'b1);
    check({tag, "_d2"}, rd_data2, exp);
    check({tag, "_p2"}, rd_perr2, exp_perr);
    check({tag, "_v1_drop"}, rd_valid1, 1'b0);
  endtask

  initial begin
    rstb = 1'b1; wr_en = 1'b0; wr_be = '0; wr_addr = '0; wr_data = '0; rd_en = 1'b0; rd_addr = '0;
    tick();
    check("rst_data", rd_data2, '0);
    check("rst_valid", rd_valid2, 1'b0);
    check("rst_perr", rd_perr2, 1'b0);
    check("rst_init", init_done2, 1'b0);
    rstb = 1'b0;

    // Clear takes 128 cycles; requests during it are ignored.
    rd_en = 1'b1; rd_addr = 7'd1;
    seen_valid = 1'b0;
    repeat (127) begin
      tick();
      seen_valid = seen_valid | rd_valid1 | rd_valid2;
    end
    rd_en = 1'b0;
    check("clr_no_valid", seen_valid, 1'b0);
    check("init_127_2", init_done2, 1'b0);
    check("init_127_1", init_done1, 1'b0);
    tick();
    check("init_128_2", init_done2, 1'b1);
    check("init_128_1", init_done1, 1'b1);

    rd("zero_0", 7'd0, '0, 1'b0);
    rd("zero_64", 7'd64, '0, 1'b0);
    rd("zero_127", 7'd127, '0, 1'b0);

    // Byte-enable merge and the wr_be=0 no-op.
    wr(7'd5, '1, '1);
    wr(7'd5, NB'(1), DW'(8'hAA));
    wr(7'd5, '0, '0);
    rd("be_5", 7'd5, {{(NB-1){8'hFF}}, 8'hAA}, 1'b0);

    // Write-first collision on the low half.
    wr(7'd9, '1, {NB{8'h11}});
    wr_en = 1'b1; wr_addr = 7'd9; wr_be = {{(NB/2){1'b0}}, {(NB/2){1'b1}}}; wr_data = {NB{8'h22}};
    rd_en = 1'b1; rd_addr = 7'd9;
    tick();
    wr_en = 1'b0; wr_be = '0; rd_en = 1'b0;
    check("coll_v1", rd_valid1, 1'b1);
    check("coll_d1", rd_data1, {{(NB/2){8'h11}}, {(NB/2){8'h22}}});
    tick();
    check("coll_v2", rd_valid2, 1'b1);
    check("coll_d2", rd_data2, {{(NB/2){8'h11}}, {(NB/2){8'h22}}});
    rd("coll_after", 7'd9, {{(NB/2){8'h11}}, {(NB/2){8'h22}}}, 1'b0);

    // Streaming reads at full throughput.
    for (int i = 0; i < 16; i++) wr(AW'(i), '1, DW'(i));
    for (int i = 0; i < 16; i++) begin
      rd_en = 1'b1; rd_addr = AW'(i);
      tick();
      check("strm_v1", rd_valid1, 1'b1);
      check("strm_d1", rd_data1, DW'(i));
      if (i > 0) begin
        check("strm_v2", rd_valid2, 1'b1);
        check("strm_d2", rd_data2, DW'(i - 1));
      end else begin
        check("strm_v2_first", rd_valid2, 1'b0);
      end
    end
    rd_en = 1'b0;
    tick();
    check("strm_v2_last", rd_valid2, 1'b1);
    check("strm_d2_last", rd_data2, DW'(15));
    check("strm_v1_end", rd_valid1, 1'b0);
    check("strm_d1_hold", rd_data1, DW'(15));
    tick();
    check("strm_v2_end", rd_valid2, 1'b0);
    check("strm_d2_hold", rd_data2, DW'(15));

    // Reset mid-operation with a read in flight, then a restart of the second clear at address 40.
    wr(7'd3, '1, DW'(8'hAB));
    rd("pre_rst_3", 7'd3, DW'(8'hAB), 1'b0);
    rd_en = 1'b1; rd_addr = 7'd3;
    tick();
    rd_en = 1'b0;
    rstb = 1'b1;
    wr_en = 1'b1; wr_addr = 7'd3; wr_be = '1; wr_data = '1;
    tick();
    check("flush_v2", rd_valid2, 1'b0);
    check("flush_d2", rd_data2, '0);
    check("flush_v1", rd_valid1, 1'b0);
    check("flush_init", init_done2, 1'b0);
    rstb = 1'b0;
    wr_addr = 7'd0; rd_en = 1'b1; rd_addr = 7'd0;
    seen_valid = 1'b0;
    repeat (40) begin
      tick();
      seen_valid = seen_valid | rd_valid1 | rd_valid2;
    end
    rstb = 1'b1;
    tick();
    rstb = 1'b0;
    repeat (127) begin
      tick();
      seen_valid = seen_valid | rd_valid1 | rd_valid2;
    end
    check("clr2_no_valid", seen_valid, 1'b0);
    check("clr2_init_127", init_done2, 1'b0);
    tick();
    wr_en = 1'b0; wr_be = '0; rd_en = 1'b0;
    check("clr2_init_128", init_done2, 1'b1);
    check("clr2_init_128_1", init_done1, 1'b1);
    rd("post_rst_3", 7'd3, '0, 1'b0);
    rd("post_rst_0", 7'd0, '0, 1'b0);

    // Parity: a flipped stored bit is flagged only on the corrupted entry.
    wr(7'd7, '1, {NB{8'h5A}});
    wr(7'd8, '1, {NB{8'h5A}});
`ifdef OCX_BRAM_PARITY_EN
    u_dut2.mem_q[7][3] = ~u_dut2.mem_q[7][3];
    u_dut1.mem_q[7][3] = ~u_dut1.mem_q[7][3];
    rd("perr_7", 7'd7, {{(NB-1){8'h5A}}, 8'h52}, 1'b1);
`else
    rd("perr_7", 7'd7, {NB{8'h5A}}, 1'b0);
`endif
    rd("perr_8", 7'd8, {NB{8'h5A}}, 1'b0);
    check("perr_idle", rd_perr2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ocx_bram_sdp_param.md
# ocx_bram_sdp_param

Parametrised simple-dual-port block RAM for the DLX data path, the successor of the fixed 512x128 SDP buffer. It is a single-clock design with byte-granular write enables and write-first forwarding for same-address collisions. A configurable 1- or 2-cycle read pipeline carries an explicit valid strobe. After every reset, a hardware clear sequencer zeroes the whole array before traffic is accepted.

## Interface
Parameters:
- DATA_WIDTH, 512, data width in bits; must be a multiple of 8.
- ADDR_WIDTH, 7, address width; DEPTH = 2**ADDR_WIDTH entries.
- OUT_REG, 1, output register stages: 1 gives 2-cycle read latency, 0 gives 1-cycle.

Ports:
- clk  in  1  clock.
- rstb  in  1  reset, synchronous, active-high.
- wr_en  in  1  write request.
- wr_be  in  DATA_WIDTH/8  byte enables; bit i covers wr_data[8i+7:8i].
- wr_addr  in  ADDR_WIDTH  write address.
- wr_data  in  DATA_WIDTH  write data.
- rd_en  in  1  read request.
- rd_addr  in  ADDR_WIDTH  read address.
- rd_data  out  DATA_WIDTH  read data, qualified by rd_valid.
- rd_valid  out  1  read data valid strobe.
- rd_perr  out  1  parity error on the current read, qualified by rd_valid.
- init_done  out  1  array cleared; requests are accepted.

## Operation
- FSM states: CLEAR and READY. rstb=1 forces CLEAR with clr_addr=0.
- CLEAR:
  - Writes zero data (and zero parity) to clr_addr each cycle, then increments clr_addr.
  - At clr_addr = DEPTH-1 the FSM moves to READY on the next edge.
  - wr_en and rd_en are ignored; no rd_valid is produced.
- READY:
  - Write: on wr_en, each byte whose wr_be bit is set is updated at wr_addr. wr_en with wr_be=0 is a no-op.
  - Read: on rd_en, the entry at rd_addr is launched down the read pipe.
  - Collision (same cycle, wr_en & rd_en, wr_addr == rd_addr): write-first. Read data takes wr_data for bytes with wr_be set and old array contents for the rest.
- The read pipe carries a valid bit alongside the data. Data registers load only when their valid input is 1, so rd_data holds its last value between reads.
- rstb mid-operation:
  - Flushes the read pipe: rd_valid=0 on the next edge.
  - Restarts CLEAR from address 0, even if a clear was already in progress.
  - Any write on the reset cycle is dropped.

## Timing
- Reset values: rd_data=0, rd_valid=0, rd_perr=0, init_done=0.
- init_done rises exactly DEPTH cycles after the first clk edge with rstb=0, i.e. the first READY cycle. This is 128 cycles at default parameters.
- Read latency from the rd_en cycle:
  - OUT_REG=0: 1 cycle.
  - OUT_REG=1: 2 cycles.
- Full throughput in both modes: one read and one write per cycle.
- A write at edge N is visible to a read issued at cycle N+1 without forwarding, and to a read issued at cycle N via forwarding.
- rd_valid is a single-cycle pulse per accepted read; back-to-back reads give back-to-back pulses.

## Configuration
- Macro: OCX_BRAM_PARITY_EN.
- With the macro defined:
  - One even-parity bit is stored per byte and computed from the written byte. Forwarded bytes use fresh parity.
  - On readout, rd_perr = OR of the per-byte parity mismatches. It is registered in the same stage as rd_data and asserted only together with rd_valid.
  - CLEAR writes parity 0.
- Without the macro: no parity storage; rd_perr is tied to 0. The port list is unchanged.

## Test plan
- Reset, then idle: init_done=0 for 128 cycles and 1 from cycle 128. Reads of addresses 0, 64 and 127 return 0 with rd_valid after 2 cycles (OUT_REG=1).
- Byte-enable write: write 0xFF..FF at address 5 with wr_be all ones, then wr_be=0x...0001 with data 0x..00AA. The read of address 5 returns 0xFF..FFAA.
- Collision: address 9 holds all 0x11. Issue a write of all 0x22 with the low half of wr_be set, plus a read of address 9, in the same cycle. The read returns the upper half 0x11.. and the lower half 0x22..
- Streaming: 16 consecutive reads of addresses 0..15, previously written with data = address, give 16 consecutive rd_valid pulses with data 0..15 in order. Repeat with OUT_REG=0 and check 1-cycle latency.
- Reset mid-operation: write address 3 = 0xAB, assert rstb for 1 cycle at CLEAR address 40 of a second clear, and have a read in flight. rd_valid drops, init_done takes 128 more cycles, then address 3 reads 0.
- With OCX_BRAM_PARITY_EN: force-flip one stored data bit at address 7 via the bench. The read of address 7 gives rd_perr=1 with rd_valid. The read of address 8 gives rd_perr=0. Without the macro, rd_perr stays 0.
